// File: rtl/width_converter_8ton.sv
`default_nettype none
// ============================================================================
// Module   : width_converter_8ton
// Purpose  : RX-path bus width converter, 8-bit bytes -> WIDTH-bit words.
//            Bytes from the I3C target FSM are packed little-endian (first
//            byte in [7:0]) and handed to the TTI RX queue. A flush closes a
//            partial word at end of transfer: the word is zero-padded and
//            tagged with its valid byte count and a last flag. A pack register
//            plus an output holding register let byte intake continue while
//            a completed word waits for the queue.
// Ports    : clk_i          - clock
//            rst_i          - asynchronous active-high reset
//            sink_valid_i   - byte valid from the target FSM
//            sink_ready_o   - byte accepted when high with sink_valid_i
//            sink_data_i    - received byte
//            sink_flush_i   - single-cycle end-of-transfer pulse
//            source_valid_o - word valid toward the RX queue
//            source_ready_i - RX queue ready
//            source_data_o  - packed word
//            source_bytes_o - valid byte count of the word (1..WIDTH/8)
//            source_last_o  - word closes a transfer
// Revision : 1.0 - initial release
// ============================================================================
module width_converter_8ton #(
    parameter int WIDTH = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 sink_valid_i,
    output logic                                 sink_ready_o,
    input  logic [7:0]                           sink_data_i,
    input  logic                                 sink_flush_i,
    output logic                                 source_valid_o,
    input  logic                                 source_ready_i,
    output logic [WIDTH-1:0]                     source_data_o,
    output logic [$clog2(WIDTH/8 > 1 ? WIDTH/8 : 2):0] source_bytes_o,
    output logic                                 source_last_o
);

    localparam int c_BYTES = WIDTH / 8;
    // Count must be able to hold the value c_BYTES itself, hence the +1 bit.
    localparam int c_CNTW  = $clog2(c_BYTES > 1 ? c_BYTES : 2) + 1;

    localparam logic [c_CNTW-1:0] c_FULL     = c_CNTW'(c_BYTES);
    localparam logic [c_CNTW-1:0] c_LAST_IDX = c_CNTW'(c_BYTES - 1);
    localparam logic [c_CNTW-1:0] c_ZERO     = '0;

    // Pack side
    logic [c_CNTW-1:0] r_pcnt;
    logic [WIDTH-1:0]  r_preg;
    logic              r_flush_pend;

    // Output holding register
    logic              r_ovalid;
    logic [WIDTH-1:0]  r_oreg;
    logic [c_CNTW-1:0] r_obytes;
    logic              r_olast;

    logic              w_sfire;
    logic              w_ofire;
    logic              w_ofree;
    logic [c_CNTW-1:0] w_n;
    logic [WIDTH-1:0]  w_packed;
    logic              w_flush_req;
    logic              w_full_load;
    logic              w_partial;
    logic              w_partial_load;
    logic              w_load;

    // Ready depends on registered state only, so there is no combinational
    // path from source_ready_i back to the target FSM. The last byte slot is
    // refused while a word is still held, because completing a word needs a
    // free output register.
    assign sink_ready_o = ~r_flush_pend & ~((r_pcnt == c_LAST_IDX) & r_ovalid);

    assign w_sfire = sink_valid_i & sink_ready_o;
    assign w_ofire = r_ovalid & source_ready_i;
    assign w_ofree = ~r_ovalid | source_ready_i;

    // Byte count after the current cycle's byte (if any) is taken.
    assign w_n = r_pcnt + {{(c_CNTW-1){1'b0}}, w_sfire};

    // Pack register with the current byte merged in. Bytes above the fill
    // point are already zero because the pack register clears on every load.
    always_comb begin
        w_packed = r_preg;
        for (int b = 0; b < c_BYTES; b++) begin
            if (w_sfire && (r_pcnt == c_CNTW'(b))) begin
                w_packed[8*b +: 8] = sink_data_i;
            end
        end
    end

    assign w_flush_req    = sink_flush_i | r_flush_pend;
    assign w_full_load    = w_sfire & (r_pcnt == c_LAST_IDX);
    assign w_partial      = w_flush_req & (w_n != c_ZERO) & (w_n < c_FULL);
    assign w_partial_load = w_partial & w_ofree;
    assign w_load         = w_full_load | w_partial_load;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pcnt       <= '0;
            r_preg       <= '0;
            r_flush_pend <= 1'b0;
            r_ovalid     <= 1'b0;
            r_oreg       <= '0;
            r_obytes     <= '0;
            r_olast      <= 1'b0;
        end else begin
            // Output register: a new load wins over draining, which gives
            // back-to-back words when the queue is ready.
            if (w_load) begin
                r_ovalid <= 1'b1;
                r_oreg   <= w_packed;
                r_obytes <= w_full_load ? c_FULL : w_n;
                r_olast  <= w_full_load ? sink_flush_i : 1'b1;
            end else if (w_ofire) begin
                r_ovalid <= 1'b0;
                r_oreg   <= '0;
                r_obytes <= '0;
                r_olast  <= 1'b0;
            end else if (w_flush_req && (w_n == c_ZERO) && r_ovalid) begin
                // Nothing partial to close: the held word becomes the last.
                r_olast <= 1'b1;
            end

            // Pack register
            if (w_load) begin
                r_pcnt       <= '0;
                r_preg       <= '0;
                r_flush_pend <= 1'b0;
            end else begin
                if (w_sfire) begin
                    r_pcnt <= w_n;
                    r_preg <= w_packed;
                end
                // Output busy: remember the flush and stall intake until the
                // partial word can be loaded.
                if (w_partial) begin
                    r_flush_pend <= 1'b1;
                end
            end
        end
    end

    assign source_valid_o = r_ovalid;
    assign source_data_o  = r_oreg;
    assign source_bytes_o = r_obytes;
    assign source_last_o  = r_olast;

endmodule
`default_nettype wire
